// File: rtl/localbp_update_queue_pkg.sv
// localbp_update_queue_pkg: local-history predictor config, queue entry type and shared LHR hash
package localbp_update_queue_pkg;
  localparam int LBP_XLEN = 32;
  localparam int LBP_M = 6;
  localparam int LBP_K = 10;
  typedef struct packed {
    logic [LBP_M-1:0] lidx;
    logic [LBP_K-1:0] paddr;
    logic [1:0]       pdata;
    logic [LBP_K-1:0] lhr;
  } bpuq_entry_t;
  // Shared with the predictor read side so both hash PCs identically
  function automatic logic [LBP_M-1:0] lhr_index(input logic [LBP_XLEN-1:0] pc);
    return {pc[LBP_M+1] ^ pc[1], pc[LBP_M:2]};
  endfunction
endpackage

// File: rtl/localbp_update_queue_fifo.sv
// localbp_update_queue_fifo: generic flop FIFO exposing every slot for associative lookup
module localbp_update_queue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [DEPTH-1:0][WIDTH-1:0] slots,
  output logic [PW-1:0]               rd_ptr,
  output logic [CW-1:0]               count,
  output logic                        full,
  output logic                        empty
);
  logic [PW-1:0] wr_ptr;
  logic wr, rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd = pop & ~empty;
  // A push into a full queue only lands when the head leaves on the same edge
  assign wr = push & (~full | rd);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  always_ff @(posedge clk)
    if (wr) slots[wr_ptr] <= din;
endmodule

// File: rtl/localbp_update_queue.sv
// localbp_update_queue: buffers resolved-branch PHT/LHR updates, drains them in order, forwards pending history
module localbp_update_queue
  import localbp_update_queue_pkg::*;
#(
  parameter int XLEN = LBP_XLEN,
  parameter int DEPTH = 4,
  localparam int m = LBP_M,
  localparam int k = LBP_K,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallW,
  input  logic            FlushW,
  input  logic            BranchM,
  input  logic            PCSrcM,
  input  logic [XLEN-1:0] PCM,
  input  logic [k-1:0]    LHRM,
  input  logic [1:0]      NewBPDirPredM,
  input  logic            WrBusy,
  input  logic [m-1:0]    IndexLHRNextF,
  output logic            PHTWrEn,
  output logic [k-1:0]    PHTWrAddr,
  output logic [1:0]      PHTWrData,
  output logic            LHRWrEn,
  output logic [m-1:0]    LHRWrIdx,
  output logic [k-1:0]    LHRWrData,
  output logic            FwdHitF,
  output logic [k-1:0]    FwdLHRF,
  output logic            QueueEmpty,
  output logic            QueueFull,
  output logic            StallReq
);
  localparam int W = $bits(bpuq_entry_t);
  logic [DEPTH-1:0][W-1:0] slots;
  logic [PW-1:0] rd_ptr, s;
  logic [CW-1:0] count;
  logic enq, deq;
  bpuq_entry_t new_e, head, e;
  assign enq = BranchM & ~StallW & ~FlushW;
  assign deq = ~QueueEmpty & ~WrBusy;
  assign StallReq = enq & QueueFull & ~deq;
  assign new_e = '{lidx: lhr_index(PCM), paddr: LHRM, pdata: NewBPDirPredM, lhr: {PCSrcM, LHRM[k-1:1]}};
  assign head = bpuq_entry_t'(slots[rd_ptr]);
  assign PHTWrEn = deq;
  assign LHRWrEn = deq;
  assign PHTWrAddr = deq ? head.paddr : '0;
  assign PHTWrData = deq ? head.pdata : '0;
  assign LHRWrIdx = deq ? head.lidx : '0;
  assign LHRWrData = deq ? head.lhr : '0;
  localbp_update_queue_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(enq),
    .pop(deq),
    .din(new_e),
    .slots(slots),
    .rd_ptr(rd_ptr),
    .count(count),
    .full(QueueFull),
    .empty(QueueEmpty)
  );
  // Walk oldest to youngest so the youngest valid match is left standing
  always_comb begin
    FwdHitF = 1'b0;
    FwdLHRF = '0;
    s = '0;
    e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s = rd_ptr + PW'(i);
      e = bpuq_entry_t'(slots[s]);
      if (CW'(i) < count && e.lidx == IndexLHRNextF) begin
        FwdHitF = 1'b1;
        FwdLHRF = e.lhr;
      end
    end
  end
endmodule

// File: tb/tb_localbp_update_queue.sv
// tb_localbp_update_queue: directed scenarios plus random traffic against a queue-based reference
module tb_localbp_update_queue;
  logic clk = 0, reset = 1;
  logic StallW = 0, FlushW = 0, BranchM = 0, PCSrcM = 0, WrBusy = 0;
  logic [31:0] PCM = 0;
  logic [9:0] LHRM = 0;
  logic [1:0] NewBPDirPredM = 0;
  logic [5:0] IndexLHRNextF = 0;
  logic PHTWrEn, LHRWrEn, FwdHitF, QueueEmpty, QueueFull, StallReq;
  logic [9:0] PHTWrAddr, LHRWrData, FwdLHRF;
  logic [1:0] PHTWrData;
  logic [5:0] LHRWrIdx;
  int asserts = 0, fails = 0;
  typedef struct {
    int lidx;
    int paddr;
    int pdata;
    int lhr;
  } ent_t;
  ent_t q[$];

  localbp_update_queue dut (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .BranchM(BranchM),
    .PCSrcM(PCSrcM), .PCM(PCM), .LHRM(LHRM), .NewBPDirPredM(NewBPDirPredM), .WrBusy(WrBusy),
    .IndexLHRNextF(IndexLHRNextF), .PHTWrEn(PHTWrEn), .PHTWrAddr(PHTWrAddr), .PHTWrData(PHTWrData),
    .LHRWrEn(LHRWrEn), .LHRWrIdx(LHRWrIdx), .LHRWrData(LHRWrData), .FwdHitF(FwdHitF),
    .FwdLHRF(FwdLHRF), .QueueEmpty(QueueEmpty), .QueueFull(QueueFull), .StallReq(StallReq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input int lhrm, input int src, input int pred);
    ent_t r;
    r.lidx = (((pc >> 7) ^ (pc >> 1)) & 1) * 32 + ((pc >> 2) & 31);
    r.paddr = lhrm;
    r.pdata = pred;
    r.lhr = src * 512 + (lhrm >> 1);
    return r;
  endfunction

  // Reference: arithmetic on a plain queue, updated on each edge
  always @(posedge clk or posedge reset)
    if (reset) q.delete();
    else begin
      int n;
      bit en, dq;
      n = q.size();
      en = BranchM && !StallW && !FlushW;
      dq = n > 0 && !WrBusy;
      if (dq) void'(q.pop_front());
      if (en && !(n == 4 && !dq)) q.push_back(mk(PCM, LHRM, PCSrcM, NewBPDirPredM));
    end

  always @(negedge clk) begin
    int n;
    bit en, dq, hit;
    int fl;
    n = q.size();
    en = BranchM && !StallW && !FlushW;
    dq = n > 0 && !WrBusy;
    hit = 0;
    fl = 0;
    for (int i = 0; i < n; i++)
      if (q[i].lidx == IndexLHRNextF) begin
        hit = 1;
        fl = q[i].lhr;
      end
    chk("empty", QueueEmpty, n == 0);
    chk("full", QueueFull, n == 4);
    chk("stallreq", StallReq, en && n == 4 && !dq);
    chk("phtwren", PHTWrEn, dq);
    chk("lhrwren", LHRWrEn, dq);
    chk("phtaddr", PHTWrAddr, dq ? q[0].paddr : 0);
    chk("phtdata", PHTWrData, dq ? q[0].pdata : 0);
    chk("lhridx", LHRWrIdx, dq ? q[0].lidx : 0);
    chk("lhrdata", LHRWrData, dq ? q[0].lhr : 0);
    chk("fwdhit", FwdHitF, hit);
    chk("fwdlhr", FwdLHRF, fl);
  end

  task automatic cyc(input bit br, input logic [31:0] pc, input int lhrm, input int src, input int pred,
                     input bit busy, input bit stall, input bit flush, input int idx);
    @(posedge clk);
    #1;
    BranchM = br;
    PCM = pc;
    LHRM = 10'(lhrm);
    PCSrcM = src[0];
    NewBPDirPredM = 2'(pred);
    WrBusy = busy;
    StallW = stall;
    FlushW = flush;
    IndexLHRNextF = 6'(idx);
    #1;
  endtask

  task automatic idle(input bit busy, input int idx);
    cyc(0, 0, 0, 0, 0, busy, 0, 0, idx);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("rst_empty", QueueEmpty, 1);
    chk("rst_wren", PHTWrEn, 0);
    // Single branch
    cyc(1, 32'h8000_0010, 'h155, 1, 3, 0, 0, 0, 0);
    chk("single_noearly", PHTWrEn, 0);
    idle(0, 0);
    chk("single_wren", PHTWrEn, 1);
    chk("single_lwren", LHRWrEn, 1);
    chk("single_addr", PHTWrAddr, 'h155);
    chk("single_data", PHTWrData, 3);
    chk("single_idx", LHRWrIdx, 'h04);
    chk("single_lhr", LHRWrData, 'h2AA);
    idle(0, 0);
    chk("single_empty", QueueEmpty, 1);
    // Back-pressure: fifth enqueue refused
    for (int i = 0; i < 5; i++) cyc(1, 32'h8000_0000 + 32'(i * 4), 'h10 + i, i & 1, i & 3, 1, 0, 0, 0);
    chk("bp_full", QueueFull, 1);
    chk("bp_stall", StallReq, 1);
    idle(1, 0);
    for (int i = 0; i < 4; i++) begin
      idle(0, 0);
      chk("bp_order", PHTWrAddr, 'h10 + i);
    end
    idle(0, 0);
    chk("bp_drained", QueueEmpty, 1);
    // Full with simultaneous enqueue and dequeue
    for (int i = 0; i < 4; i++) cyc(1, 32'h0000_0100, 'h20 + i, 0, 1, 1, 0, 0, 0);
    cyc(1, 32'h0000_0104, 'h3C, 1, 2, 0, 0, 0, 0);
    chk("fulldeq_stall", StallReq, 0);
    chk("fulldeq_wren", PHTWrEn, 1);
    for (int i = 0; i < 4; i++) begin
      idle(0, 0);
      chk("fulldeq_order", PHTWrAddr, i == 3 ? 'h3C : 'h21 + i);
      if (i == 0) chk("fulldeq_full", QueueFull, 1);
    end
    idle(0, 0);
    // Forwarding: youngest wins, head being written still counts
    cyc(1, 32'h8000_0010, 'h155, 1, 3, 1, 0, 0, 4);
    cyc(1, 32'h8000_0010, 'h2AA, 0, 0, 1, 0, 0, 4);
    idle(1, 4);
    chk("fwd_hit", FwdHitF, 1);
    chk("fwd_lhr", FwdLHRF, 'h155);
    idle(0, 4);
    chk("fwd_hit_drain", FwdHitF, 1);
    chk("fwd_lhr_drain", FwdLHRF, 'h155);
    idle(0, 4);
    idle(0, 4);
    chk("fwd_gone", FwdHitF, 0);
    // Gating by flush and stall
    cyc(1, 32'h8000_0010, 'h155, 1, 3, 0, 0, 1, 0);
    cyc(1, 32'h8000_0010, 'h155, 1, 3, 0, 1, 0, 0);
    idle(0, 0);
    chk("gate_empty", QueueEmpty, 1);
    chk("gate_wren", PHTWrEn, 0);
    // Mid-cycle reset with three entries held
    for (int i = 0; i < 3; i++) cyc(1, 32'h8000_0010, 'h40 + i, 0, 1, 1, 0, 0, 4);
    idle(0, 4);
    chk("prerst_wren", PHTWrEn, 1);
    #1 reset = 1;
    #1;
    chk("midrst_empty", QueueEmpty, 1);
    chk("midrst_wren", PHTWrEn, 0);
    chk("midrst_addr", PHTWrAddr, 0);
    chk("midrst_fwd", FwdHitF, 0);
    @(negedge clk);
    #1 reset = 0;
    idle(0, 4);
    chk("postrst_wren", PHTWrEn, 0);
    chk("postrst_empty", QueueEmpty, 1);
    // Random traffic, narrow PC/index range to provoke forwarding hits
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 9) < 6, $urandom & 32'h8000_009E, $urandom_range(0, 1023),
          $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) | ($urandom_range(0, 1) * 32));
    idle(0, 0);
    repeat (6) idle(0, 0);
    chk("final_empty", QueueEmpty, 1);
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
